// File: rtl/lfsr_mem_checker.sv
// lfsr_mem_checker: drives the LFSR pattern generator and a single-port RAM
// through a write pass and a read/compare pass. It reports pass/fail, a
// saturating mismatch count and the address of the first failing read.

module lfsr_mem_checker #(
   parameter int NUM_OPS = 1023,
   parameter int ERR_W   = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             i_start,
   output logic             o_lfsr_rstn,
   output logic             o_en_addr,
   output logic             o_en_data,
   input  logic [9:0]       i_lfsr_addr,
   input  logic [31:0]      i_lfsr_data,
   output logic             o_mem_en,
   output logic             o_mem_we,
   output logic [9:0]       o_mem_addr,
   output logic [31:0]      o_mem_wdata,
   input  logic [31:0]      i_mem_rdata,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_pass,
   output logic [ERR_W-1:0] o_err_count,
   output logic [9:0]       o_first_err_addr
);

   typedef enum logic [3:0] {
      IDLE,
      SEED_W,
      STRB_W,
      WR,
      SEED_R,
      STRB_R,
      RD,
      CMP,
      FIN
   } stateT;

   localparam logic [9:0] OPS_LAST = 10'(NUM_OPS - 1);

   stateT             r_state;
   stateT             w_nextState;
   logic [9:0]        r_opCnt;
   logic [31:0]       r_expData;
   logic [9:0]        r_expAddr;
   logic [ERR_W-1:0]  r_errCnt;
   logic [9:0]        r_firstErr;
   logic              r_pass;
   logic              r_en;
   logic              r_lfsrRstn;
   logic              w_lastOp;
   logic              w_mismatch;
   logic              w_memEn;
   logic              w_memWe;
   logic [9:0]        w_memAddr;
   logic [31:0]       w_memWdata;

   assign w_lastOp   = (r_opCnt == OPS_LAST);
   assign w_mismatch = (i_mem_rdata != r_expData);

   // Next-state decode plus the RAM command, which is taken straight from the
   // generator outputs while they are stable in WR and RD.
   always_comb begin
      w_nextState = r_state;
      w_memEn     = 1'b0;
      w_memWe     = 1'b0;
      w_memAddr   = 10'd0;
      w_memWdata  = 32'd0;
      case (r_state)
         IDLE: begin
            if (i_start) w_nextState = SEED_W;
         end
         SEED_W: w_nextState = STRB_W;
         STRB_W: w_nextState = WR;
         WR: begin
            w_memEn     = 1'b1;
            w_memWe     = 1'b1;
            w_memAddr   = i_lfsr_addr;
            w_memWdata  = i_lfsr_data;
            w_nextState = w_lastOp ? SEED_R : STRB_W;
         end
         SEED_R: w_nextState = STRB_R;
         STRB_R: w_nextState = RD;
         RD: begin
            w_memEn     = 1'b1;
            w_memAddr   = i_lfsr_addr;
            w_nextState = CMP;
         end
         CMP:     w_nextState = w_lastOp ? FIN : STRB_R;
         FIN:     w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // State register; the generator strobe and reseed are registered from the
   // next state so they are glitch-free for the whole STRB_*/SEED_* cycle.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state    <= IDLE;
         r_en       <= 1'b0;
         r_lfsrRstn <= 1'b0;
      end else begin
         r_state    <= w_nextState;
         r_en       <= (w_nextState == STRB_W) || (w_nextState == STRB_R);
         r_lfsrRstn <= !((w_nextState == SEED_W) || (w_nextState == SEED_R));
      end
   end

   // Operation counter, shared by both passes and wrapped back to zero at the
   // end of each pass.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_opCnt <= 10'd0;
      end else if (r_state == IDLE && i_start) begin
         r_opCnt <= 10'd0;
      end else if (r_state == WR || r_state == CMP) begin
         r_opCnt <= w_lastOp ? 10'd0 : r_opCnt + 10'd1;
      end
   end

   // Capture the expected data and its address while the generator holds
   // them, so the compare one cycle later lines up with the RAM read data.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_expData <= 32'd0;
         r_expAddr <= 10'd0;
      end else if (r_state == RD) begin
         r_expData <= i_lfsr_data;
         r_expAddr <= i_lfsr_addr;
      end
   end

   // Result registers: cleared on start, updated on each compare, and the
   // pass flag resolved once the whole read pass has finished. A zero count
   // means no error has been seen yet because the count never wraps.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_errCnt   <= '0;
         r_firstErr <= 10'd0;
         r_pass     <= 1'b0;
      end else if (r_state == IDLE && i_start) begin
         r_errCnt   <= '0;
         r_firstErr <= 10'd0;
         r_pass     <= 1'b0;
      end else if (r_state == CMP && w_mismatch) begin
         if (r_errCnt == '0) r_firstErr <= r_expAddr;
         if (r_errCnt != '1) r_errCnt <= r_errCnt + ERR_W'(1);
      end else if (r_state == FIN) begin
         r_pass <= (r_errCnt == '0);
      end
   end

   assign o_lfsr_rstn      = r_lfsrRstn;
   assign o_en_addr        = r_en;
   assign o_en_data        = r_en;
   assign o_mem_en         = w_memEn;
   assign o_mem_we         = w_memWe;
   assign o_mem_addr       = w_memAddr;
   assign o_mem_wdata      = w_memWdata;
   assign o_busy           = (r_state != IDLE);
   assign o_done           = (r_state == FIN);
   assign o_pass           = r_pass;
   assign o_err_count      = r_errCnt;
   assign o_first_err_addr = r_firstErr;

endmodule
